id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//  Registered, parametrised instruction-decode stage between IF/ID and EX. Decodes MIPS
//  logic/shift ops, reads the regfile, forwards results from EX and MEM, detects load-use
//  hazards and holds the decoded bundle in an ID/EX output register with valid/ready
//  handshake, flush, and a saturating stall-cycle counter.
// PARAMETERS
//  DATA_W       32  operand/result width, >= 32; immediates extended to DATA_W
//  REG_AW       5   register address width
//  FWD_EN       1   1 = EX/MEM forwarding enabled; 0 = regfile data only
//  STALL_CNT_W  16  width of the stall-cycle counter
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        synchronous reset, active-high
//  in_valid     in   1        pc_i/inst_i hold a valid instruction
//  in_ready     out  1        stage accepts the instruction this cycle
//  pc_i         in   32       instruction address
//  inst_i       in   32       instruction word
//  reg1_read_o  out  1        regfile port 1 read enable (combinational)
//  reg2_read_o  out  1        regfile port 2 read enable (combinational)
//  reg1_addr_o  out  REG_AW   = inst_i[25:21]
//  reg2_addr_o  out  REG_AW   = inst_i[20:16]
//  reg1_data_i  in   DATA_W   regfile port 1 data
//  reg2_data_i  in   DATA_W   regfile port 2 data
//  ex_wreg_i / ex_wd_i / ex_wdata_i / ex_is_load_i  in 1/REG_AW/DATA_W/1  EX-stage writeback
//  mem_wreg_i / mem_wd_i / mem_wdata_i              in 1/REG_AW/DATA_W    MEM-stage writeback
//  flush_i      in   1        discard output register content and incoming instruction
//  out_valid    out  1        ID/EX register holds a valid bundle
//  out_ready    in   1        EX consumes bundle when out_valid && out_ready
//  aluop_o / alusel_o  out 8/3  registered ALU op / result select
//  reg1_o / reg2_o     out DATA_W  registered operands
//  wd_o / wreg_o       out REG_AW/1  registered dest address / write enable
//  pc_o         out  32       registered pc
//  inst_err_o   out  1        registered: bundle came from an undecodable instruction
//  stall_cnt_o  out  STALL_CNT_W  load-use stall cycles, saturates at all-ones
// BEHAVIOUR
//  - Reset: out_valid=0, aluop_o=0, alusel_o=0, reg1_o=reg2_o=0, wd_o=0, wreg_o=0,
//    pc_o=0, inst_err_o=0, stall_cnt_o=0. Read enables 0 while rst=1.
//  - Decode (op=[31:26], funct=[5:0], sa=[10:6]); others -> NOP, wreg=0, inst_err=1:
//    ORI 001101/ANDI 001100/XORI 001110: rs op zext(imm16) -> rt; LUI 001111: imm16<<16 -> rt
//      (encoded as OR with $0). SPECIAL 000000: AND 100100, OR 100101, XOR 100110,
//      NOR 100111 rs,rt -> rd; SLL 000000, SRL 000010, SRA 000011 rt by sa -> rd
//      (reg1_o = zext(sa), reg2_o = rt). All-zero word = NOP, inst_err=0.
//    aluop: OR 0x25 AND 0x24 XOR 0x26 NOR 0x27 SLL 0x7C SRL 0x02 SRA 0x03 NOP 0x00;
//    alusel: NOP 0, LOGIC 1, SHIFT 2. Unread operand slot takes the extended immediate.
//  - Operand source per read port, priority: addr==0 -> 0; EX match (ex_wreg_i, ex_wd_i==addr,
//    !ex_is_load_i) -> ex_wdata_i; MEM match -> mem_wdata_i; else regfile. FWD_EN=0 skips both.
//  - load_use = in_valid && ex_wreg_i && ex_is_load_i && ex_wd_i!=0 && a read port reads ex_wd_i.
//  - in_ready = (!out_valid || out_ready) && !load_use && !flush_i (combinational).
//  - Clock edge: flush_i -> out_valid<=0 (highest priority, data regs don't care);
//    else accept (in_valid&&in_ready) -> load bundle, out_valid<=1;
//    else out_valid&&out_ready -> out_valid<=0; else hold all registers unchanged.
//  - Latency 1 cycle accept->out_valid; full throughput 1/cycle with out_ready=1.
//  - stall_cnt_o += 1 each cycle load_use && !flush_i; saturates, never wraps.
//  - Bundle stable while out_valid && !out_ready. Reset mid-stall clears counter and valid.
// TESTING
//  1. ori $1,$0,0x1100 (0x34011100), out_ready=1 -> next cycle out_valid=1, aluop=0x25,
//     alusel=1, reg1_o=0, reg2_o=0x00001100, wd_o=1, wreg_o=1.
//  2. or $3,$1,$2 with ex_wd=1 ex_wdata=0xA5A5A5A5, mem_wd=2 mem_wdata=0x0F0F0F0F, regfile
//     returns 0 -> reg1_o=0xA5A5A5A5, reg2_o=0x0F0F0F0F; EX and MEM both target $1 -> EX wins.
//  3. ex_is_load_i=1 ex_wd=1, and $4,$1,$2 presented 3 cycles -> in_ready=0, out_valid falls,
//     stall_cnt_o=3; load clears -> accepted next edge.
//  4. out_ready=0 for 5 cycles with out_valid=1 -> bundle bits unchanged, in_ready=0.
//  5. flush_i pulse with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, nothing taken.
//  6. STALL_CNT_W=2, 6 stall cycles -> stall_cnt_o=3; inst 0xFC000000 -> inst_err_o=1,
//     wreg_o=0; rst=1 mid-stall -> all outputs reset values next edge.

Source files
------------

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage with an ID/EX output register.
// Decodes MIPS logic and shift ops, reads the regfile, and forwards results from EX and MEM.
// A load in EX whose destination is read by this instruction holds the instruction back.
// stall_cnt_o counts the cycles lost to such load-use stalls and saturates at all-ones.
module id_stage_pipe #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_AW      = 5,
  parameter bit          FWD_EN      = 1'b1,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            pc_i,
  input  logic [31:0]            inst_i,
  output logic                   reg1_read_o,
  output logic                   reg2_read_o,
  output logic [REG_AW-1:0]      reg1_addr_o,
  output logic [REG_AW-1:0]      reg2_addr_o,
  input  logic [DATA_W-1:0]      reg1_data_i,
  input  logic [DATA_W-1:0]      reg2_data_i,
  input  logic                   ex_wreg_i,
  input  logic [REG_AW-1:0]      ex_wd_i,
  input  logic [DATA_W-1:0]      ex_wdata_i,
  input  logic                   ex_is_load_i,
  input  logic                   mem_wreg_i,
  input  logic [REG_AW-1:0]      mem_wd_i,
  input  logic [DATA_W-1:0]      mem_wdata_i,
  input  logic                   flush_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             aluop_o,
  output logic [2:0]             alusel_o,
  output logic [DATA_W-1:0]      reg1_o,
  output logic [DATA_W-1:0]      reg2_o,
  output logic [REG_AW-1:0]      wd_o,
  output logic                   wreg_o,
  output logic [31:0]            pc_o,
  output logic                   inst_err_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam logic [7:0] AluNop = 8'h00;
  localparam logic [7:0] AluOr  = 8'h25;
  localparam logic [7:0] AluAnd = 8'h24;
  localparam logic [7:0] AluXor = 8'h26;
  localparam logic [7:0] AluNor = 8'h27;
  localparam logic [7:0] AluSll = 8'h7C;
  localparam logic [7:0] AluSrl = 8'h02;
  localparam logic [7:0] AluSra = 8'h03;

  localparam logic [2:0] SelNop   = 3'd0;
  localparam logic [2:0] SelLogic = 3'd1;
  localparam logic [2:0] SelShift = 3'd2;

  logic [5:0]        op, funct;
  logic [7:0]        dec_aluop;
  logic [2:0]        dec_alusel;
  logic              dec_wreg, dec_err;
  logic [REG_AW-1:0] dec_wd;
  logic [DATA_W-1:0] dec_imm;
  logic [DATA_W-1:0] op1, op2;
  logic              load_use, accept;

  assign op          = inst_i[31:26];
  assign funct       = inst_i[5:0];
  assign reg1_addr_o = REG_AW'(inst_i[25:21]);
  assign reg2_addr_o = REG_AW'(inst_i[20:16]);

  // Instruction decode; anything unrecognised becomes a flagged NOP
  always_comb begin
    dec_aluop   = AluNop;
    dec_alusel  = SelNop;
    dec_wreg    = 1'b0;
    dec_err     = 1'b1;
    dec_wd      = REG_AW'(inst_i[15:11]);
    dec_imm     = '0;
    reg1_read_o = 1'b0;
    reg2_read_o = 1'b0;
    case (op)
      6'b001101, 6'b001100, 6'b001110, 6'b001111: begin
        dec_alusel  = SelLogic;
        dec_wreg    = 1'b1;
        dec_err     = 1'b0;
        dec_wd      = REG_AW'(inst_i[20:16]);
        reg1_read_o = 1'b1;
        dec_imm     = DATA_W'(inst_i[15:0]);
        case (op)
          6'b001100: dec_aluop = AluAnd;
          6'b001110: dec_aluop = AluXor;
          6'b001111: begin
            // LUI: rs is $0 in a legal encoding, so rs | (imm << 16) is the result
            dec_aluop = AluOr;
            dec_imm   = DATA_W'({inst_i[15:0], 16'h0000});
          end
          default:   dec_aluop = AluOr;
        endcase
      end
      6'b000000: begin
        case (funct)
          6'b100100, 6'b100101, 6'b100110, 6'b100111: begin
            dec_alusel  = SelLogic;
            dec_wreg    = 1'b1;
            dec_err     = 1'b0;
            reg1_read_o = 1'b1;
            reg2_read_o = 1'b1;
            case (funct)
              6'b100100: dec_aluop = AluAnd;
              6'b100110: dec_aluop = AluXor;
              6'b100111: dec_aluop = AluNor;
              default:   dec_aluop = AluOr;
            endcase
          end
          6'b000000, 6'b000010, 6'b000011: begin
            dec_err = 1'b0;
            // All-zero word is the canonical NOP, not "sll $0,$0,0"
            if (inst_i != 32'h0) begin
              dec_alusel  = SelShift;
              dec_wreg    = 1'b1;
              reg2_read_o = 1'b1;
              dec_imm     = DATA_W'(inst_i[10:6]);
              case (funct)
                6'b000010: dec_aluop = AluSrl;
                6'b000011: dec_aluop = AluSra;
                default:   dec_aluop = AluSll;
              endcase
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    if (rst) begin
      reg1_read_o = 1'b0;
      reg2_read_o = 1'b0;
    end
  end

  // Operand 1: $0, then EX forward (non-load), then MEM forward, then regfile
  always_comb begin
    op1 = dec_imm;
    if (reg1_read_o) begin
      if (reg1_addr_o == '0) begin
        op1 = '0;
      end else if (FWD_EN && ex_wreg_i && !ex_is_load_i && ex_wd_i == reg1_addr_o) begin
        op1 = ex_wdata_i;
      end else if (FWD_EN && mem_wreg_i && mem_wd_i == reg1_addr_o) begin
        op1 = mem_wdata_i;
      end else begin
        op1 = reg1_data_i;
      end
    end
  end

  // Operand 2: same priority as operand 1
  always_comb begin
    op2 = dec_imm;
    if (reg2_read_o) begin
      if (reg2_addr_o == '0) begin
        op2 = '0;
      end else if (FWD_EN && ex_wreg_i && !ex_is_load_i && ex_wd_i == reg2_addr_o) begin
        op2 = ex_wdata_i;
      end else if (FWD_EN && mem_wreg_i && mem_wd_i == reg2_addr_o) begin
        op2 = mem_wdata_i;
      end else begin
        op2 = reg2_data_i;
      end
    end
  end

  assign load_use = in_valid && ex_wreg_i && ex_is_load_i && (ex_wd_i != '0) &&
                    ((reg1_read_o && reg1_addr_o == ex_wd_i) ||
                     (reg2_read_o && reg2_addr_o == ex_wd_i));
  assign in_ready = (!out_valid || out_ready) && !load_use && !flush_i;
  assign accept   = in_valid && in_ready;

  // ID/EX register: flush beats accept, accept beats drain; otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      aluop_o    <= '0;
      alusel_o   <= '0;
      reg1_o     <= '0;
      reg2_o     <= '0;
      wd_o       <= '0;
      wreg_o     <= 1'b0;
      pc_o       <= '0;
      inst_err_o <= 1'b0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      aluop_o    <= dec_aluop;
      alusel_o   <= dec_alusel;
      reg1_o     <= op1;
      reg2_o     <= op2;
      wd_o       <= dec_wd;
      wreg_o     <= dec_wreg;
      pc_o       <= pc_i;
      inst_err_o <= dec_err;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of load-use stall cycles; flushed cycles are not stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (load_use && !flush_i && stall_cnt_o != '1) begin
      stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios followed by randomized traffic.
// The randomized traffic is checked against a mnemonic-level reference model.
module tb_id_stage_pipe;

  localparam int unsigned CntW   = 4;
  localparam int unsigned CntMax = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] pc_i, inst_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
  logic [4:0]  ex_wd_i, mem_wd_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic        flush_i, out_valid, out_ready;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [31:0] reg1_o, reg2_o, pc_o;
  logic [4:0]  wd_o;
  logic        wreg_o, inst_err_o;
  logic [CntW-1:0] stall_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_stage_pipe #(
    .DATA_W     (32),
    .REG_AW     (5),
    .FWD_EN     (1'b1),
    .STALL_CNT_W(CntW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pc_i        (pc_i),
    .inst_i      (inst_i),
    .reg1_read_o (reg1_read_o),
    .reg2_read_o (reg2_read_o),
    .reg1_addr_o (reg1_addr_o),
    .reg2_addr_o (reg2_addr_o),
    .reg1_data_i (reg1_data_i),
    .reg2_data_i (reg2_data_i),
    .ex_wreg_i   (ex_wreg_i),
    .ex_wd_i     (ex_wd_i),
    .ex_wdata_i  (ex_wdata_i),
    .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i  (mem_wreg_i),
    .mem_wd_i    (mem_wd_i),
    .mem_wdata_i (mem_wdata_i),
    .flush_i     (flush_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .aluop_o     (aluop_o),
    .alusel_o    (alusel_o),
    .reg1_o      (reg1_o),
    .reg2_o      (reg2_o),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .pc_o        (pc_o),
    .inst_err_o  (inst_err_o),
    .stall_cnt_o (stall_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; inst_i = 32'h0; pc_i = 32'h0;
    reg1_data_i = 32'h0; reg2_data_i = 32'h0;
    ex_wreg_i = 1'b0; ex_wd_i = 5'd0; ex_wdata_i = 32'h0; ex_is_load_i = 1'b0;
    mem_wreg_i = 1'b0; mem_wd_i = 5'd0; mem_wdata_i = 32'h0;
    flush_i = 1'b0; out_ready = 1'b1;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       r1, r2, wreg, err;
    logic [7:0] aluop;
    logic [2:0] sel;
    logic [4:0] wd;
    logic [31:0] imm;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    d = '0;
    d.err = 1'b1;
    if (w == 32'h0) begin
      d.err = 1'b0;
    end else if (op inside {6'b001100, 6'b001101, 6'b001110, 6'b001111}) begin
      d.err = 0; d.wreg = 1; d.sel = 3'd1; d.r1 = 1; d.wd = w[20:16];
      d.aluop = (op == 6'b001100) ? 8'h24 : (op == 6'b001110) ? 8'h26 : 8'h25;
      d.imm = (op == 6'b001111) ? {w[15:0], 16'h0} : {16'h0, w[15:0]};
    end else if (op == 6'd0 && fn inside {6'h24, 6'h25, 6'h26, 6'h27}) begin
      d.err = 0; d.wreg = 1; d.sel = 3'd1; d.r1 = 1; d.r2 = 1; d.wd = w[15:11];
      d.aluop = {2'b00, fn};
    end else if (op == 6'd0 && fn inside {6'h00, 6'h02, 6'h03}) begin
      d.err = 0; d.wreg = 1; d.sel = 3'd2; d.r2 = 1; d.wd = w[15:11];
      d.aluop = (fn == 6'h00) ? 8'h7C : {2'b00, fn};
      d.imm = {27'h0, w[10:6]};
    end
    return d;
  endfunction

  function automatic logic [31:0] opnd(input logic rd, input logic [4:0] a,
                                       input logic [31:0] rf, input logic [31:0] imm);
    if (!rd) return imm;
    if (a == 5'd0) return 32'h0;
    if (ex_wreg_i && !ex_is_load_i && ex_wd_i == a) return ex_wdata_i;
    if (mem_wreg_i && mem_wd_i == a) return mem_wdata_i;
    return rf;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;
    logic [31:0] w;
    rs = 5'($urandom_range(3)); rt = 5'($urandom_range(3)); rd = 5'($urandom_range(3));
    sa = 5'($urandom); imm = 16'($urandom);
    case ($urandom_range(13))
      0:  w = {6'b001101, rs, rt, imm};
      1:  w = {6'b001100, rs, rt, imm};
      2:  w = {6'b001110, rs, rt, imm};
      3:  w = {6'b001111, 5'd0, rt, imm};
      4:  w = {6'd0, rs, rt, rd, 5'd0, 6'b100100};
      5:  w = {6'd0, rs, rt, rd, 5'd0, 6'b100101};
      6:  w = {6'd0, rs, rt, rd, 5'd0, 6'b100110};
      7:  w = {6'd0, rs, rt, rd, 5'd0, 6'b100111};
      8:  w = {6'd0, 5'd0, rt, rd, sa, 6'b000000};
      9:  w = {6'd0, 5'd0, rt, rd, sa, 6'b000010};
      10: w = {6'd0, 5'd0, rt, rd, sa, 6'b000011};
      11: w = 32'h0;
      12: w = {6'b111111, 26'($urandom)};
      default: w = {6'd0, rs, rt, rd, 5'd0, 6'b101010};
    endcase
    return w;
  endfunction

  // model state
  logic        m_valid, m_wreg, m_err;
  logic [7:0]  m_aluop;
  logic [2:0]  m_sel;
  logic [31:0] m_r1, m_r2, m_pc;
  logic [4:0]  m_wd;
  int          m_cnt;

  initial begin
    dec_t d;
    logic lu, rdy;
    logic [31:0] e1, e2;

    idle();
    rst = 1'b1;
    in_valid = 1'b1; inst_i = 32'h34011100;
    @(negedge clk);
    check("rst_rd1", reg1_read_o, 0);
    check("rst_rd2", reg2_read_o, 0);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_aluop", aluop_o, 0);
    check("rst_alusel", alusel_o, 0);
    check("rst_reg1", reg1_o, 0);
    check("rst_reg2", reg2_o, 0);
    check("rst_wd", wd_o, 0);
    check("rst_wreg", wreg_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_err", inst_err_o, 0);
    check("rst_cnt", stall_cnt_o, 0);

    // ori $1,$0,0x1100
    rst = 1'b0; pc_i = 32'h100; reg1_data_i = 32'hDEAD;
    #1 check("t1_rd1", reg1_read_o, 1);
    @(negedge clk);
    check("t1_valid", out_valid, 1);
    check("t1_aluop", aluop_o, 8'h25);
    check("t1_alusel", alusel_o, 1);
    check("t1_reg1", reg1_o, 0);
    check("t1_reg2", reg2_o, 32'h00001100);
    check("t1_wd", wd_o, 1);
    check("t1_wreg", wreg_o, 1);
    check("t1_pc", pc_o, 32'h100);

    // or $3,$1,$2 with EX forwarding $1 and MEM forwarding $2
    inst_i = 32'h00221825; reg1_data_i = 0; reg2_data_i = 0;
    ex_wreg_i = 1; ex_wd_i = 1; ex_wdata_i = 32'hA5A5A5A5;
    mem_wreg_i = 1; mem_wd_i = 2; mem_wdata_i = 32'h0F0F0F0F;
    @(negedge clk);
    check("t2_reg1", reg1_o, 32'hA5A5A5A5);
    check("t2_reg2", reg2_o, 32'h0F0F0F0F);
    check("t2_wd", wd_o, 3);
    // EX and MEM both target $1: EX wins
    mem_wd_i = 1; mem_wdata_i = 32'h12345678; reg2_data_i = 32'h55;
    @(negedge clk);
    check("t2_ex_prio", reg1_o, 32'hA5A5A5A5);
    check("t2_rf", reg2_o, 32'h55);

    // and $4,$1,$2 behind a load to $1
    mem_wreg_i = 0; ex_is_load_i = 1; inst_i = 32'h00222024;
    reg1_data_i = 32'h11; reg2_data_i = 32'h22;
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_ready", in_ready, 0);
      @(negedge clk);
    end
    check("t3_valid", out_valid, 0);
    check("t3_cnt", stall_cnt_o, 3);
    ex_wreg_i = 0; ex_is_load_i = 0;
    #1 check("t3_ready_clr", in_ready, 1);
    @(negedge clk);
    check("t3_accept", out_valid, 1);
    check("t3_aluop", aluop_o, 8'h24);
    check("t3_reg1", reg1_o, 32'h11);

    // backpressure for 5 cycles with xori $5,$0,0xBEEF waiting
    out_ready = 0; inst_i = 32'h3805BEEF;
    for (int i = 0; i < 5; i++) begin
      #1 check("t4_ready", in_ready, 0);
      @(negedge clk);
      check("t4_valid", out_valid, 1);
      check("t4_aluop", aluop_o, 8'h24);
      check("t4_wd", wd_o, 4);
      check("t4_reg1", reg1_o, 32'h11);
    end
    out_ready = 1;
    @(negedge clk);
    check("t4_next_aluop", aluop_o, 8'h26);
    check("t4_next_reg2", reg2_o, 32'h0000BEEF);
    check("t4_next_wd", wd_o, 5);

    // flush with both a valid bundle and a valid instruction
    inst_i = 32'h34011100; flush_i = 1;
    #1 check("t5_ready", in_ready, 0);
    @(negedge clk);
    check("t5_valid", out_valid, 0);
    flush_i = 0; in_valid = 0;
    @(negedge clk);
    check("t5_nothing", out_valid, 0);
    check("t5_held", aluop_o, 8'h26);

    // counter saturation
    in_valid = 1; inst_i = 32'h00222024; ex_wreg_i = 1; ex_wd_i = 1; ex_is_load_i = 1;
    for (int i = 0; i < 12; i++) @(negedge clk);
    check("t6_cnt_max", stall_cnt_o, CntMax);
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("t6_cnt_sat", stall_cnt_o, CntMax);
    // undecodable instruction
    ex_wreg_i = 0; ex_is_load_i = 0; inst_i = 32'hFC000000; pc_i = 32'h200;
    @(negedge clk);
    check("t6_err", inst_err_o, 1);
    check("t6_err_wreg", wreg_o, 0);
    check("t6_err_aluop", aluop_o, 0);
    check("t6_err_sel", alusel_o, 0);
    // reset in the middle of a stall
    inst_i = 32'h00222024; ex_wreg_i = 1; ex_is_load_i = 1;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("t6_rst_cnt", stall_cnt_o, 0);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_err", inst_err_o, 0);
    check("t6_rst_pc", pc_o, 0);
    check("t6_rst_aluop", aluop_o, 0);
    rst = 0; flush_i = 1;
    @(negedge clk);
    check("t6_flush_nocount", stall_cnt_o, 0);
    flush_i = 0;
    @(negedge clk);
    check("t6_count", stall_cnt_o, 1);

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("r_valid", out_valid, m_valid);
        check("r_aluop", aluop_o, m_aluop);
        check("r_alusel", alusel_o, m_sel);
        check("r_reg1", reg1_o, m_r1);
        check("r_reg2", reg2_o, m_r2);
        check("r_wreg", wreg_o, m_wreg);
        check("r_pc", pc_o, m_pc);
        check("r_err", inst_err_o, m_err);
        check("r_cnt", stall_cnt_o, m_cnt);
        if (m_wreg) check("r_wd", wd_o, m_wd);
      end
      rst = (i == 0) || ($urandom_range(99) == 0);
      in_valid = ($urandom_range(9) < 7);
      inst_i = gen_inst();
      pc_i = $urandom;
      reg1_data_i = $urandom; reg2_data_i = $urandom;
      ex_wreg_i = $urandom_range(1); ex_wd_i = 5'($urandom_range(3));
      ex_wdata_i = $urandom; ex_is_load_i = ($urandom_range(3) == 0);
      mem_wreg_i = $urandom_range(1); mem_wd_i = 5'($urandom_range(3));
      mem_wdata_i = $urandom;
      flush_i = ($urandom_range(19) == 0);
      out_ready = ($urandom_range(9) < 7);
      #1;
      d = decode(inst_i);
      if (rst) begin
        d.r1 = 0; d.r2 = 0;
      end
      lu = in_valid && ex_wreg_i && ex_is_load_i && ex_wd_i != 0 &&
           ((d.r1 && inst_i[25:21] == ex_wd_i) || (d.r2 && inst_i[20:16] == ex_wd_i));
      rdy = (!m_valid || out_ready) && !lu && !flush_i;
      e1 = opnd(d.r1, inst_i[25:21], reg1_data_i, d.imm);
      e2 = opnd(d.r2, inst_i[20:16], reg2_data_i, d.imm);
      check("r_rd1", reg1_read_o, d.r1);
      check("r_rd2", reg2_read_o, d.r2);
      check("r_addr1", reg1_addr_o, inst_i[25:21]);
      check("r_addr2", reg2_addr_o, inst_i[20:16]);
      check("r_ready", in_ready, rdy);
      @(posedge clk);
      if (rst) begin
        m_valid = 0; m_aluop = 0; m_sel = 0; m_r1 = 0; m_r2 = 0; m_wd = 0;
        m_wreg = 0; m_pc = 0; m_err = 0; m_cnt = 0;
      end else begin
        if (lu && !flush_i && m_cnt < CntMax) m_cnt++;
        if (flush_i) begin
          m_valid = 0;
        end else if (in_valid && rdy) begin
          m_valid = 1; m_aluop = d.aluop; m_sel = d.sel; m_r1 = e1; m_r2 = e2;
          m_wd = d.wd; m_wreg = d.wreg; m_pc = pc_i; m_err = d.err;
        end else if (m_valid && out_ready) begin
          m_valid = 0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
